// File: rtl/core_frame_rx.sv
// rtl/core_frame_rx.sv - per-core receiver: captures masked bus words, unpacks them into IMEM, starts the core
// Instruction 0 of each bus word sits in the low INSTR_SIZE bits; IMEM writes are K instructions wide.
module core_frame_rx #(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = 16,
  parameter int INSTR_SIZE  = 16,
  parameter int BUS_TO_CORE = 32,
  parameter int IMEM_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bus_valid,
  input  logic [BUS_TO_CORE-1:0]        bus_data,
  input  logic [CORE_NUM-1:0]           bus_mask,
  input  logic                          bus_last,
  output logic                          bus_ready,
  output logic                          core_ready,
  output logic                          core_reading,
  output logic                          run_start,
  output logic [$clog2(IMEM_DEPTH):0]   instr_count,
  output logic                          load_err,
  input  logic                          core_done,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_raddr,
  output logic [INSTR_SIZE-1:0]         imem_rdata
);

  localparam int K  = BUS_TO_CORE / INSTR_SIZE;
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CORE_NUM-1:0] SEL_BIT = CORE_NUM'(1) << CORE_ID;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic                  r_ovf;
  logic                  r_run_start;
  logic                  r_load_err;
  logic [INSTR_SIZE-1:0] r_rdata;
  logic [INSTR_SIZE-1:0] r_imem [IMEM_DEPTH];

  logic          w_sel;
  logic          w_bus_ready;
  logic          w_accept;
  logic          w_word_ovf;
  logic          w_ovf_next;
  logic          w_we;
  logic [AW-1:0] w_wr_base;

  assign w_sel       = |(bus_mask & SEL_BIT);
  assign w_bus_ready = (r_state != S_RUN);
  assign w_accept    = bus_valid & w_sel & w_bus_ready;
  // A full IMEM leaves wr_ptr parked at IMEM_DEPTH; further words are dropped and flagged.
  assign w_word_ovf  = (r_wr_ptr == PW'(IMEM_DEPTH));
  assign w_ovf_next  = r_ovf | w_word_ovf;
  assign w_we        = w_accept & ~w_word_ovf;
  assign w_wr_base   = r_wr_ptr[AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_ovf       <= 1'b0;
      r_run_start <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_run_start <= 1'b0;
      r_load_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            if (!w_word_ovf) r_wr_ptr <= r_wr_ptr + PW'(K);
            if (bus_last) begin
              if (w_ovf_next) begin
                r_state    <= S_IDLE;
                r_wr_ptr   <= '0;
                r_ovf      <= 1'b0;
                r_load_err <= 1'b1;
              end else begin
                r_state     <= S_RUN;
                r_run_start <= 1'b1;
              end
            end else begin
              r_state <= S_LOAD;
              r_ovf   <= w_ovf_next;
            end
          end
        end
        S_RUN: begin
          if (core_done) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < K; k++) begin
        r_imem[w_wr_base + AW'(k)] <= bus_data[k*INSTR_SIZE +: INSTR_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rdata <= '0;
    else        r_rdata <= r_imem[imem_raddr];
  end

  assign bus_ready    = w_bus_ready;
  assign core_ready   = (r_state == S_IDLE);
  assign core_reading = (r_state == S_LOAD);
  assign run_start    = r_run_start;
  assign load_err     = r_load_err;
  assign instr_count  = (r_state == S_RUN) ? r_wr_ptr : '0;
  assign imem_rdata   = r_rdata;

endmodule

// File: tb/tb_core_frame_rx.sv
// tb/tb_core_frame_rx.sv - self-checking bench for core_frame_rx against an array-based IMEM model
module tb_core_frame_rx;
  localparam int CORE_ID = 0, CORE_NUM = 16, INSTR_SIZE = 16, BUS_TO_CORE = 32, IMEM_DEPTH = 64;
  localparam int K = BUS_TO_CORE / INSTR_SIZE;
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int MAX_WORDS = IMEM_DEPTH / K;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   bus_valid = 1'b0;
  logic [BUS_TO_CORE-1:0] bus_data = '0;
  logic [CORE_NUM-1:0]    bus_mask = '0;
  logic                   bus_last = 1'b0;
  logic                   bus_ready, core_ready, core_reading, run_start, load_err;
  logic [AW:0]            instr_count;
  logic                   core_done = 1'b0;
  logic [AW-1:0]          imem_raddr = '0;
  logic [INSTR_SIZE-1:0]  imem_rdata;

  int total = 0;
  int bad = 0;
  int cnt_rs = 0;
  int cnt_le = 0;
  logic [INSTR_SIZE-1:0] exp_mem [IMEM_DEPTH];

  core_frame_rx #(.CORE_ID(CORE_ID), .CORE_NUM(CORE_NUM), .INSTR_SIZE(INSTR_SIZE),
                  .BUS_TO_CORE(BUS_TO_CORE), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus_valid(bus_valid), .bus_data(bus_data), .bus_mask(bus_mask),
    .bus_last(bus_last), .bus_ready(bus_ready), .core_ready(core_ready), .core_reading(core_reading),
    .run_start(run_start), .instr_count(instr_count), .load_err(load_err), .core_done(core_done),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (run_start === 1'b1) cnt_rs++;
    if (load_err === 1'b1) cnt_le++;
  end

  task automatic send_word(input logic [BUS_TO_CORE-1:0] d, input logic [CORE_NUM-1:0] m, input logic l);
    bus_valid = 1'b1; bus_data = d; bus_mask = m; bus_last = l;
    @(negedge clk);
    bus_valid = 1'b0; bus_last = 1'b0;
  endtask

  task automatic read_mem(input int a, output logic [INSTR_SIZE-1:0] d);
    imem_raddr = AW'(a);
    @(negedge clk);
    @(negedge clk);
    d = imem_rdata;
  endtask

  task automatic model_word(input int word_idx, input logic [BUS_TO_CORE-1:0] d);
    for (int k = 0; k < K; k++) begin
      if (word_idx * K + k < IMEM_DEPTH) exp_mem[word_idx*K + k] = d[k*INSTR_SIZE +: INSTR_SIZE];
    end
  endtask

  task automatic finish_run();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    int rs0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (imem_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", imem_rdata); end
    reset = 1'b1;
    rs0 = cnt_rs;
    repeat (5) @(negedge clk);
    total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL reset_core_ready: got %0b want 1", core_ready); end
    total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL reset_bus_ready: got %0b want 1", bus_ready); end
    total++; if (core_reading !== 1'b0) begin bad++; $display("FAIL reset_core_reading: got %0b want 0", core_reading); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL reset_instr_count: got %0d want 0", instr_count); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_load_err: got %0b want 0", load_err); end
    total++; if (cnt_rs != rs0 || run_start !== 1'b0) begin bad++; $display("FAIL reset_run_start: got %0d pulses want 0", cnt_rs - rs0); end
  endtask

  task automatic test_basic_load();
    logic [INSTR_SIZE-1:0] d;
    send_word(32'h2222_1111, 16'h000f, 1'b0);
    model_word(0, 32'h2222_1111);
    total++; if (core_reading !== 1'b1 || core_ready !== 1'b0 || bus_ready !== 1'b1) begin
      bad++; $display("FAIL basic_loading: got rd=%0b cr=%0b br=%0b want 1 0 1", core_reading, core_ready, bus_ready); end
    send_word(32'h4444_3333, 16'h000f, 1'b1);
    model_word(1, 32'h4444_3333);
    total++; if (run_start !== 1'b1) begin bad++; $display("FAIL basic_run_start: got %0b want 1", run_start); end
    total++; if (instr_count !== 7'd4) begin bad++; $display("FAIL basic_instr_count: got %0d want 4", instr_count); end
    total++; if (bus_ready !== 1'b0 || core_ready !== 1'b0 || core_reading !== 1'b0) begin
      bad++; $display("FAIL basic_run_flags: got br=%0b cr=%0b rd=%0b want 0 0 0", bus_ready, core_ready, core_reading); end
    @(negedge clk);
    total++; if (run_start !== 1'b0 || instr_count !== 7'd4) begin
      bad++; $display("FAIL basic_pulse_hold: got rs=%0b cnt=%0d want 0 4", run_start, instr_count); end
    for (int a = 0; a < 4; a++) begin
      read_mem(a, d);
      total++; if (d !== exp_mem[a]) begin bad++; $display("FAIL basic_imem[%0d]: got %0h want %0h", a, d, exp_mem[a]); end
    end
    finish_run();
    total++; if (core_ready !== 1'b1 || instr_count !== '0) begin
      bad++; $display("FAIL basic_done: got cr=%0b cnt=%0d want 1 0", core_ready, instr_count); end
  endtask

  task automatic test_other_mask();
    logic [INSTR_SIZE-1:0] d;
    int rs0;
    rs0 = cnt_rs;
    send_word(32'hdead_beef, 16'h00f0, 1'b0);
    total++; if (core_reading !== 1'b0 || core_ready !== 1'b1) begin
      bad++; $display("FAIL mask_ignored: got rd=%0b cr=%0b want 0 1", core_reading, core_ready); end
    send_word(32'hcafe_f00d, 16'h00f0, 1'b1);
    @(negedge clk);
    total++; if (cnt_rs != rs0 || core_ready !== 1'b1) begin
      bad++; $display("FAIL mask_no_run: got pulses=%0d cr=%0b want 0 1", cnt_rs - rs0, core_ready); end
    for (int a = 0; a < 4; a++) begin
      read_mem(a, d);
      total++; if (d !== exp_mem[a]) begin bad++; $display("FAIL mask_imem[%0d]: got %0h want %0h", a, d, exp_mem[a]); end
    end
  endtask

  task automatic test_run_blocking();
    logic [BUS_TO_CORE-1:0] w;
    logic [INSTR_SIZE-1:0] d;
    w = $urandom;
    send_word(w, 16'h0001, 1'b1);
    model_word(0, w);
    total++; if (run_start !== 1'b1 || instr_count !== 7'd2) begin
      bad++; $display("FAIL block_start: got rs=%0b cnt=%0d want 1 2", run_start, instr_count); end
    bus_valid = 1'b1; bus_mask = 16'h0001; bus_data = $urandom; bus_last = 1'b1;
    total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL block_bus_ready: got %0b want 0", bus_ready); end
    @(negedge clk);
    total++; if (core_ready !== 1'b0 || instr_count !== 7'd2 || run_start !== 1'b0) begin
      bad++; $display("FAIL block_held: got cr=%0b cnt=%0d rs=%0b want 0 2 0", core_ready, instr_count, run_start); end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0; bus_valid = 1'b0; bus_last = 1'b0;
    total++; if (core_ready !== 1'b1 || instr_count !== '0 || core_reading !== 1'b0) begin
      bad++; $display("FAIL block_done: got cr=%0b cnt=%0d rd=%0b want 1 0 0", core_ready, instr_count, core_reading); end
    read_mem(2, d);
    total++; if (d !== exp_mem[2]) begin bad++; $display("FAIL block_imem2: got %0h want %0h", d, exp_mem[2]); end
  endtask

  task automatic test_overflow();
    logic [BUS_TO_CORE-1:0] w;
    logic [INSTR_SIZE-1:0] d;
    int rs0, le0, a;
    rs0 = cnt_rs; le0 = cnt_le;
    for (int i = 0; i <= MAX_WORDS; i++) begin
      w = $urandom;
      send_word(w, 16'h0001, (i == MAX_WORDS));
      model_word(i, w);
      if (i < MAX_WORDS && (load_err !== 1'b0 || core_reading !== 1'b1)) begin
        total++; bad++; $display("FAIL ovf_loading word %0d: got le=%0b rd=%0b want 0 1", i, load_err, core_reading);
      end
    end
    total++; if (load_err !== 1'b1 || run_start !== 1'b0) begin
      bad++; $display("FAIL ovf_pulse: got le=%0b rs=%0b want 1 0", load_err, run_start); end
    total++; if (core_ready !== 1'b1 || core_reading !== 1'b0) begin
      bad++; $display("FAIL ovf_idle: got cr=%0b rd=%0b want 1 0", core_ready, core_reading); end
    @(negedge clk);
    total++; if (cnt_le - le0 != 1 || cnt_rs != rs0) begin
      bad++; $display("FAIL ovf_counts: got le=%0d rs=%0d want 1 0", cnt_le - le0, cnt_rs - rs0); end
    for (int j = 0; j < 6; j++) begin
      a = $urandom_range(0, IMEM_DEPTH - 1);
      read_mem(a, d);
      total++; if (d !== exp_mem[a]) begin bad++; $display("FAIL ovf_imem[%0d]: got %0h want %0h", a, d, exp_mem[a]); end
    end
    for (int i = 0; i < MAX_WORDS; i++) begin
      w = $urandom;
      send_word(w, 16'h0001, (i == MAX_WORDS - 1));
      model_word(i, w);
    end
    total++; if (run_start !== 1'b1 || load_err !== 1'b0 || instr_count !== 7'(IMEM_DEPTH)) begin
      bad++; $display("FAIL full_exact: got rs=%0b le=%0b cnt=%0d want 1 0 %0d", run_start, load_err, instr_count, IMEM_DEPTH); end
    read_mem(IMEM_DEPTH - 1, d);
    total++; if (d !== exp_mem[IMEM_DEPTH-1]) begin bad++; $display("FAIL full_top: got %0h want %0h", d, exp_mem[IMEM_DEPTH-1]); end
    finish_run();
  endtask

  task automatic test_reset_mid_load();
    logic [BUS_TO_CORE-1:0] w;
    logic [INSTR_SIZE-1:0] d;
    int rs0, le0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      send_word(w, 16'h0001, 1'b0);
      model_word(i, w);
    end
    total++; if (core_reading !== 1'b1) begin bad++; $display("FAIL rst_pre_loading: got %0b want 1", core_reading); end
    #2 reset = 1'b0;
    #1;
    total++; if (core_reading !== 1'b0 || core_ready !== 1'b1 || bus_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async: got rd=%0b cr=%0b br=%0b want 0 1 1", core_reading, core_ready, bus_ready); end
    rs0 = cnt_rs; le0 = cnt_le;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (cnt_rs != rs0 || cnt_le != le0) begin
      bad++; $display("FAIL rst_no_pulse: got rs=%0d le=%0d want 0 0", cnt_rs - rs0, cnt_le - le0); end
    w = $urandom;
    send_word(w, 16'h0001, 1'b1);
    model_word(0, w);
    total++; if (run_start !== 1'b1 || instr_count !== 7'd2) begin
      bad++; $display("FAIL rst_fresh: got rs=%0b cnt=%0d want 1 2", run_start, instr_count); end
    for (int a = 0; a < 3; a++) begin
      read_mem(a, d);
      total++; if (d !== exp_mem[a]) begin bad++; $display("FAIL rst_imem[%0d]: got %0h want %0h", a, d, exp_mem[a]); end
    end
    finish_run();
  endtask

  task automatic test_random();
    logic [BUS_TO_CORE-1:0] w;
    logic [CORE_NUM-1:0] m;
    logic [INSTR_SIZE-1:0] d;
    int len;
    for (int t = 0; t < 20; t++) begin
      len = (t % 5 == 4) ? $urandom_range(MAX_WORDS + 1, MAX_WORDS + 3) : $urandom_range(1, MAX_WORDS);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          m = CORE_NUM'($urandom); m[CORE_ID] = 1'b0;
          send_word($urandom, m, 1'($urandom));
        end
        if ($urandom_range(0, 3) == 0) begin
          bus_mask = '1; bus_data = $urandom;
          @(negedge clk);
        end
        w = $urandom;
        m = CORE_NUM'($urandom); m[CORE_ID] = 1'b1;
        send_word(w, m, (i == len - 1));
        model_word(i, w);
      end
      if (len > MAX_WORDS) begin
        total++; if (load_err !== 1'b1 || run_start !== 1'b0 || core_ready !== 1'b1) begin
          bad++; $display("FAIL rnd%0d_ovf: got le=%0b rs=%0b cr=%0b want 1 0 1", t, load_err, run_start, core_ready); end
      end else begin
        total++; if (run_start !== 1'b1 || instr_count !== 7'(len * K)) begin
          bad++; $display("FAIL rnd%0d_run: got rs=%0b cnt=%0d want 1 %0d", t, run_start, instr_count, len * K); end
        for (int a = 0; a < len * K; a++) begin
          read_mem(a, d);
          total++; if (d !== exp_mem[a]) begin bad++; $display("FAIL rnd%0d_imem[%0d]: got %0h want %0h", t, a, d, exp_mem[a]); end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        finish_run();
        total++; if (core_ready !== 1'b1 || instr_count !== '0) begin
          bad++; $display("FAIL rnd%0d_done: got cr=%0b cnt=%0d want 1 0", t, core_ready, instr_count); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_other_mask();
    test_run_blocking();
    test_overflow();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
